load_store_unit: RTL
====================

# load_store_unit

Sits between the CPU memory-access stage and the word-addressed data memory (1024 × 32-bit, synchronous write, registered read on `MemRead`). It turns byte-addressed load/store requests of byte, halfword or word size into word accesses. It performs lane extraction with sign/zero extension for loads and read-modify-write for sub-word stores. It flags misaligned and out-of-range accesses without touching memory.

## Interface
Parameters:
- `MEM_WORDS`, 1024: depth of the attached data memory in 32-bit words.

Ports:
- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `ReqValid`  in  1  CPU request valid.
- `ReqReady`  out  1  unit can accept a request.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `ReqSize`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `ReqUnsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `ReqAddr`  in  32  byte address.
- `ReqWData`  in  32  store data, right-aligned.
- `RspValid`  out  1  one-cycle completion pulse.
- `RspData`  out  32  load result; 0 for stores and errors.
- `RspError`  out  1  valid with `RspValid`: misaligned, illegal size or out of range.
- `MemAddress`  out  32  word index (`ReqAddr >> 2`).
- `MemWriteData`  out  32  word to write.
- `MemWriteEnable`  out  1  memory write strobe.
- `MemRead`  out  1  memory read strobe.
- `MemReadData`  in  32  memory registered read data.

## Operation
- FSM states: IDLE, READ, LATCH, RMW_WRITE, WRITE, DONE.
- IDLE: `ReqReady`=1. When `ReqValid` is 1, the request is captured into internal registers.
- On capture, the next state is chosen as follows:
  - Error (illegal size, half with `addr[0]`≠0, word with `addr[1:0]`≠0, or `addr>>2` ≥ `MEM_WORDS`): DONE.
  - Load: READ.
  - Word store: WRITE.
  - Byte or half store: READ.
- READ: `MemRead`=1. Next state is LATCH for loads and RMW_WRITE for stores.
- LATCH: `MemReadData` is valid. `RspData` ← extracted and extended lane. Next state is DONE.
- RMW_WRITE: `MemWriteEnable`=1. `MemWriteData` = `MemReadData` with the target lane replaced by the low bits of the captured `ReqWData`. Next state is DONE.
- WRITE: `MemWriteEnable`=1. `MemWriteData` = captured `ReqWData`. Next state is DONE.
- DONE: `RspValid`=1 for exactly one cycle. `RspError` is set for error requests. Next state is IDLE.
- Lane mapping is little-endian:
  - Byte k = `addr[1:0]` occupies bits [8k+7:8k].
  - Half h = `addr[1]` occupies bits [16h+15:16h].
- `MemRead` and `MemWriteEnable` are never both 1.
- `MemAddress` is 0 in IDLE and DONE.
- Error requests assert neither memory strobe.

## Timing
- Reset state is IDLE. Reset values:
  - `ReqReady`=1.
  - `RspValid`, `RspError`, `RspData`, `MemRead`, `MemWriteEnable`, `MemWriteData`, `MemAddress` all 0.
- Memory strobes are forced to 0 in any cycle where `Reset`=1. Reset in the middle of an operation aborts it with no memory write on that edge.
- `RspValid` asserts this many cycles after the accept edge:
  - Load: 3 (READ, LATCH, DONE).
  - Word store: 2.
  - Sub-word store: 3.
  - Error: 1.
- `ReqReady`=0 outside IDLE. The CPU stalls on `!ReqReady`. The request must be held while `ReqValid` is 1 and `ReqReady` is 0.
- The captured request is immune to input changes after the accept edge.
- A new request can be accepted in the cycle after DONE. There is no back-to-back acceptance in DONE.
- `RspData` holds its value until the next LATCH or reset. It reads as 0 during `RspValid` for stores and errors.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`;
  - the FSM state enum;
  - the `MEM_WORDS` default.
- Sub-module `lsu_lane_align` (purely combinational) provides:
  - load extract and extend from (word, `addr[1:0]`, size, unsigned);
  - store merge from (old word, new data, `addr[1:0]`, size).
- The FSM and the request registers stay in `load_store_unit`.

## Test plan
- Memory word 5 = 0x8899AABB. Signed byte load at 0x15 → `RspData`=0xFFFFFFAA, `RspError`=0, `RspValid` 3 cycles after accept, `MemAddress`=5 during READ.
- Same memory contents. Unsigned half load at 0x16 → 0x00008899. Signed half load at 0x16 → 0xFFFF8899. Word load at 0x14 → 0x8899AABB.
- Byte store of 0x11 at 0x17 → READ then RMW_WRITE, word 5 = 0x1199AABB. Word store of 0xDEADBEEF at 0x20 → single write, word 8 = 0xDEADBEEF, `RspValid` 2 cycles after accept.
- Error requests: half load at 0x15, word store at 0x1002, size 11, and word load at 0x1000 (index 1024) → `RspError`=1 after 1 cycle, `MemRead`=`MemWriteEnable`=0 throughout.
- `Reset` asserted during RMW_WRITE of a half store → no write occurs, FSM returns to IDLE, `ReqReady`=1 on the next cycle, all outputs at reset values.
- Change `ReqAddr` and `ReqWData` after acceptance, and hold `ReqValid` high continuously → the original request completes unchanged, the next request is accepted only in IDLE, and exactly one `RspValid` pulse occurs per accepted request.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared encodings for the load/store unit: access sizes,
//             FSM states and the default data-memory depth.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  // Access size encodings carried on ReqSize
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Depth of the attached data memory in 32-bit words
  localparam int MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_LATCH     = 3'd2,
    ST_RMW_WRITE = 3'd3,
    ST_WRITE     = 3'd4,
    ST_DONE      = 3'd5
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : CPU request/response handshake plus data-memory port of the
//             load/store unit. The master side is the environment (CPU and
//             memory); the slave side is the unit itself.
//  Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if;

  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqUnsigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspError;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic        MemRead;
  logic [31:0] MemReadData;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
    output MemReadData,
    input  ReqReady, RspValid, RspData, RspError,
    input  MemAddress, MemWriteData, MemWriteEnable, MemRead
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
    input  MemReadData,
    output ReqReady, RspValid, RspData, RspError,
    output MemAddress, MemWriteData, MemWriteEnable, MemRead
  );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Purpose  : Little-endian lane handling. Extracts and sign/zero-extends a
//             byte or halfword from a memory word for loads, and merges
//             right-aligned store data into the old word for sub-word stores.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_load_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_new_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: select the addressed lane, then extend it to 32 bits
  always_comb begin
    w_byte      = 8'h00;
    w_half      = i_offset[1] ? i_load_word[31:16] : i_load_word[15:0];
    o_load_data = i_load_word;
    case (i_offset)
      2'd0:    w_byte = i_load_word[7:0];
      2'd1:    w_byte = i_load_word[15:8];
      2'd2:    w_byte = i_load_word[23:16];
      default: w_byte = i_load_word[31:24];
    endcase
    case (i_size)
      SIZE_BYTE: o_load_data = i_unsigned ? {24'h000000, w_byte}
                                          : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = i_unsigned ? {16'h0000, w_half}
                                          : {{16{w_half[15]}}, w_half};
      default:   o_load_data = i_load_word;
    endcase
  end

  // Store path: overwrite only the target lane of the old word
  always_comb begin
    o_store_word = i_old_word;
    case (i_size)
      SIZE_BYTE: o_store_word[{i_offset, 3'b000} +: 8]     = i_new_data[7:0];
      SIZE_HALF: o_store_word[{i_offset[1], 4'b0000} +: 16] = i_new_data[15:0];
      default:   o_store_word = i_new_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Converts byte-addressed byte/half/word loads and stores into
//             word accesses on a synchronous data memory, with
//             read-modify-write for sub-word stores and error reporting for
//             misaligned, illegal-size and out-of-range requests.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  load_store_unit_if.slave  bus
);

  localparam logic [31:0] c_mem_words = MEM_WORDS;

  lsu_state_t  r_state;
  lsu_state_t  w_next_state;
  logic        r_write;
  logic        r_unsigned;
  logic        r_error;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_req_error;
  logic        w_accept;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  assign w_accept = (r_state == ST_IDLE) && bus.ReqValid;

  lsu_lane_align u_lane_align (
    .i_load_word  (bus.MemReadData),
    .i_offset     (r_addr[1:0]),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_old_word   (bus.MemReadData),
    .i_new_data   (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // Classify the incoming request: bad size, misalignment or beyond memory
  always_comb begin
    w_req_error = ({2'b00, bus.ReqAddr[31:2]} >= c_mem_words);
    case (bus.ReqSize)
      SIZE_HALF:    if (bus.ReqAddr[0])        w_req_error = 1'b1;
      SIZE_WORD:    if (|bus.ReqAddr[1:0])     w_req_error = 1'b1;
      SIZE_ILLEGAL: w_req_error = 1'b1;
      default:      ;
    endcase
  end

  // State register, request capture and load-result holding register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_error    <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write    <= bus.ReqWrite;
        r_unsigned <= bus.ReqUnsigned;
        r_error    <= w_req_error;
        r_size     <= bus.ReqSize;
        r_addr     <= bus.ReqAddr;
        r_wdata    <= bus.ReqWData;
      end
      if (r_state == ST_LATCH) begin
        r_rdata <= w_load_data;
      end
    end
  end

  // Next-state and output decode; every output is quiet while Reset is high
  always_comb begin
    w_next_state       = r_state;
    bus.ReqReady       = (r_state == ST_IDLE);
    bus.MemRead        = 1'b0;
    bus.MemWriteEnable = 1'b0;
    bus.MemAddress     = 32'h0;
    bus.MemWriteData   = 32'h0;
    bus.RspValid       = 1'b0;
    bus.RspError       = 1'b0;
    bus.RspData        = r_rdata;

    case (r_state)
      ST_IDLE: begin
        if (bus.ReqValid) begin
          if (w_req_error)                    w_next_state = ST_DONE;
          else if (!bus.ReqWrite)             w_next_state = ST_READ;
          else if (bus.ReqSize == SIZE_WORD)  w_next_state = ST_WRITE;
          else                                w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        bus.MemRead    = 1'b1;
        bus.MemAddress = {2'b00, r_addr[31:2]};
        w_next_state   = r_write ? ST_RMW_WRITE : ST_LATCH;
      end
      ST_LATCH: begin
        bus.MemAddress = {2'b00, r_addr[31:2]};
        w_next_state   = ST_DONE;
      end
      ST_RMW_WRITE: begin
        bus.MemWriteEnable = 1'b1;
        bus.MemAddress     = {2'b00, r_addr[31:2]};
        bus.MemWriteData   = w_store_word;
        w_next_state       = ST_DONE;
      end
      ST_WRITE: begin
        bus.MemWriteEnable = 1'b1;
        bus.MemAddress     = {2'b00, r_addr[31:2]};
        bus.MemWriteData   = r_wdata;
        w_next_state       = ST_DONE;
      end
      ST_DONE: begin
        bus.RspValid = 1'b1;
        bus.RspError = r_error;
        if (r_write || r_error) bus.RspData = 32'h0;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase

    if (Reset) begin
      bus.MemRead        = 1'b0;
      bus.MemWriteEnable = 1'b0;
      bus.MemAddress     = 32'h0;
      bus.MemWriteData   = 32'h0;
      bus.RspValid       = 1'b0;
      bus.RspError       = 1'b0;
      bus.RspData        = 32'h0;
    end
  end

endmodule
`default_nettype wire
